fib_seq_engine: RTL and testbench
=================================

// Module: fib_seq_engine
// PURPOSE
//  Parametrised successor of the single-width Fibonacci accelerator. Computes Fibonacci F(n) or
//  Lucas L(n) at one iteration per clock, with configurable widths, overflow detection
//  (wrap or saturate) and abort.
//  Sits behind the MessagePack-RPC dispatcher and uses the same ready/valid/accept call handshake.
// PARAMETERS
//  DATA_WIDTH  32  result width (unsigned), >= 2
//  N_WIDTH     32  argument width (signed two's complement), >= 2
//  SATURATE    0   0: wrap modulo 2^DATA_WIDTH on overflow; 1: clamp to all-ones
// PORTS
//  clk            in   1           clock, all logic on rising edge
//  rst            in   1           synchronous reset, active-high
//  fib_ready      in   1           call request; sampled only in IDLE
//  fib_in_n       in   N_WIDTH     signed argument n, captured with fib_ready
//  fib_in_mode    in   1           0 = Fibonacci (seeds 0,1), 1 = Lucas (seeds 2,1); captured with fib_ready
//  fib_abort      in   1           cancel a running computation (honoured in LOOP only)
//  fib_accept     in   1           result consumed; honoured only while fib_valid=1
//  fib_valid      out  1           result available; held until accepted
//  fib_out_0      out  DATA_WIDTH  result value; stable while fib_valid=1
//  fib_out_ovf    out  1           sticky overflow flag for this call; valid with fib_valid
//  fib_busy       out  1           1 while state != IDLE (combinational decode of state)
// BEHAVIOUR
//  Reset: state=IDLE, fib_valid=0, fib_out_0=0, fib_out_ovf=0; internal regs r0, r1, i and n cleared.
//   Reset in any state, including LOOP or DONE, discards the call; no valid is produced.
//  States: IDLE, LOOP, DONE (2-bit encoding).
//  IDLE: when fib_ready=1 at an edge:
//   - latch n=fib_in_n; r0=seed0 (0 or 2, by mode); r1=1; i=1; ovf=0; go to LOOP.
//   - fib_valid is already 0.
//  LOOP, evaluated once per edge, priority top-down:
//   1. fib_abort=1 -> IDLE; outputs unchanged; fib_valid stays 0.
//   2. n<=0 (signed compare) -> fib_out_0<=r0 (0, or 2 in Lucas mode), fib_out_ovf<=0,
//      fib_valid<=1 -> DONE.
//   3. i>=n -> fib_out_0<=r1, fib_out_ovf<=ovf, fib_valid<=1 -> DONE.
//   4. else: r0<=r1; r1<=sum; i<=i+1; stay in LOOP.
//  Sum arithmetic: s = {1'b0,r0}+{1'b0,r1} in DATA_WIDTH+1 bits.
//   - If carry s[DATA_WIDTH]=1: ovf<=1 (sticky for this call).
//   - The new r1 is s[DATA_WIDTH-1:0] if SATURATE=0, else {DATA_WIDTH{1'b1}}.
//   - Once saturated, r1 stays all-ones: every later sum also carries.
//  Latency: let E0 be the capture edge. LOOP runs k = (n<=0 ? 1 : n) edges, and fib_valid=1 after
//   edge E0+k. Example: n=10 gives valid 10 cycles after capture.
//  i is an N_WIDTH unsigned counter. It cannot wrap because it stops at n <= 2^(N_WIDTH-1)-1.
//  DONE: fib_valid=1, fib_out_0 and fib_out_ovf held.
//   - fib_accept=1 at an edge -> fib_valid<=0, go to IDLE.
//   - fib_ready present in the same cycle as accept is NOT captured; the caller re-presents it
//     next cycle. Earliest back-to-back capture is the edge after the accept edge.
//   - fib_abort is ignored in DONE; fib_ready is ignored in LOOP and DONE.
//  fib_accept while fib_valid=0 is ignored.
// TESTING
//  1. Reset, then n=10, mode=0 -> valid after 10 cycles, out=55, ovf=0. Hold accept low 5 cycles:
//     out stays 55. Accept -> valid=0 next cycle.
//  2. n=0 mode 0 -> out=0; n=-7 mode 1 -> out=2; n=1 mode 0 -> out=1.
//     Each has valid 1 cycle after capture.
//  3. Lucas: n=5, mode=1 -> out=11 after 5 cycles; n=10, mode=1 -> out=123.
//  4. DATA_WIDTH=8, SATURATE=0: n=13 -> out=233, ovf=0; n=14 -> out=121, ovf=1.
//     Same with SATURATE=1: n=14 -> out=255, ovf=1; n=20 -> out=255, ovf=1.
//  5. Abort: n=30, assert fib_abort at cycle 5 -> IDLE, no valid, busy=0 next cycle.
//     A new request n=3 then -> out=2.
//  6. Mid-op reset during LOOP and during DONE -> valid=0, out=0, ovf=0, busy=0.
//     Also: ready+accept in the same DONE cycle -> no new capture; re-presented ready next cycle
//     is captured.

Source files
------------

// File: rtl/fib_seq_engine.sv
// Fibonacci / Lucas sequence engine: one recurrence step per clock, with wrap or
// saturate overflow handling, abort, and a ready/valid/accept call handshake.
module fib_seq_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_WIDTH    = 32,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fib_ready,
    input  logic signed [N_WIDTH-1:0] fib_in_n,
    input  logic                      fib_in_mode,
    input  logic                      fib_abort,
    input  logic                      fib_accept,
    output logic                      fib_valid,
    output logic [DATA_WIDTH-1:0]     fib_out_0,
    output logic                      fib_out_ovf,
    output logic                      fib_busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoop = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic signed [N_WIDTH-1:0] n_q, n_d;
    logic [N_WIDTH-1:0]        i_q, i_d;
    logic [DATA_WIDTH-1:0]     r0_q, r0_d;
    logic [DATA_WIDTH-1:0]     r1_q, r1_d;
    logic [DATA_WIDTH-1:0]     out_q, out_d;
    logic                      ovf_q, ovf_d;
    logic                      out_ovf_q, out_ovf_d;
    logic                      valid_q, valid_d;

    logic [DATA_WIDTH:0]       sum;
    logic                      n_nonpos;
    logic                      i_reached;

    // Extra bit catches the carry that marks overflow.
    assign sum       = {1'b0, r0_q} + {1'b0, r1_q};
    assign n_nonpos  = n_q[N_WIDTH-1] || (n_q == '0);
    // Only consulted when n > 0, so an unsigned compare is exact.
    assign i_reached = (i_q >= $unsigned(n_q));

    assign fib_valid   = valid_q;
    assign fib_out_0   = out_q;
    assign fib_out_ovf = out_ovf_q;
    assign fib_busy    = (state_q != StIdle);

    // Next-state and datapath update for the call FSM.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        i_d       = i_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        out_d     = out_q;
        ovf_d     = ovf_q;
        out_ovf_d = out_ovf_q;
        valid_d   = valid_q;

        case (state_q)
            StIdle: begin
                if (fib_ready) begin
                    n_d     = fib_in_n;
                    r0_d    = fib_in_mode ? DATA_WIDTH'(2) : '0;
                    r1_d    = DATA_WIDTH'(1);
                    i_d     = N_WIDTH'(1);
                    ovf_d   = 1'b0;
                    state_d = StLoop;
                end
            end
            StLoop: begin
                if (fib_abort) begin
                    state_d = StIdle;
                end else if (n_nonpos) begin
                    out_d     = r0_q;
                    out_ovf_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = StDone;
                end else if (i_reached) begin
                    out_d     = r1_q;
                    out_ovf_d = ovf_q;
                    valid_d   = 1'b1;
                    state_d   = StDone;
                end else begin
                    r0_d = r1_q;
                    // Once clamped, r1 stays all-ones since every later sum carries.
                    r1_d = (SATURATE && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
                    ovf_d = ovf_q | sum[DATA_WIDTH];
                    i_d   = i_q + N_WIDTH'(1);
                end
            end
            StDone: begin
                // A ready arriving with accept is dropped; caller re-presents it.
                if (fib_accept) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            n_q       <= '0;
            i_q       <= '0;
            r0_q      <= '0;
            r1_q      <= '0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
            out_ovf_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            i_q       <= i_d;
            r0_q      <= r0_d;
            r1_q      <= r1_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
            out_ovf_q <= out_ovf_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: three instances (32-bit wrap, 8-bit wrap, 8-bit saturate)
// share stimulus and are checked against a closed-form sequence model.
module tb_fib_seq_engine;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ready = 1'b0;
    logic signed [31:0] in_n = '0;
    logic               mode = 1'b0;
    logic               abort = 1'b0;
    logic               accept = 1'b0;

    logic        valid_a, ovf_a, busy_a;
    logic [31:0] out_a;
    logic        valid_b, ovf_b, busy_b;
    logic [7:0]  out_b;
    logic        valid_c, ovf_c, busy_c;
    logic [7:0]  out_c;

    int n_vec = 0;
    int n_err = 0;

    longint unsigned fib_tab [0:82];

    always #5 clk = ~clk;

    fib_seq_engine #(.DATA_WIDTH(32), .N_WIDTH(32), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .fib_ready(ready), .fib_in_n(in_n), .fib_in_mode(mode),
        .fib_abort(abort), .fib_accept(accept), .fib_valid(valid_a), .fib_out_0(out_a),
        .fib_out_ovf(ovf_a), .fib_busy(busy_a)
    );
    fib_seq_engine #(.DATA_WIDTH(8), .N_WIDTH(8), .SATURATE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .fib_ready(ready), .fib_in_n(in_n[7:0]), .fib_in_mode(mode),
        .fib_abort(abort), .fib_accept(accept), .fib_valid(valid_b), .fib_out_0(out_b),
        .fib_out_ovf(ovf_b), .fib_busy(busy_b)
    );
    fib_seq_engine #(.DATA_WIDTH(8), .N_WIDTH(8), .SATURATE(1'b1)) dut_c (
        .clk(clk), .rst(rst), .fib_ready(ready), .fib_in_n(in_n[7:0]), .fib_in_mode(mode),
        .fib_abort(abort), .fib_accept(accept), .fib_valid(valid_c), .fib_out_0(out_c),
        .fib_out_ovf(ovf_c), .fib_busy(busy_c)
    );

    // Exact sequence value: F(n), or L(n) = F(n-1) + F(n+1); n <= 0 yields the seed.
    function automatic longint unsigned true_val(input int n, input bit m);
        if (n <= 0) return m ? 64'd2 : 64'd0;
        return m ? fib_tab[n-1] + fib_tab[n+1] : fib_tab[n];
    endfunction

    function automatic int exp_lat(input int n);
        return (n <= 0) ? 1 : n;
    endfunction

    // Drive one call and wait (bounded) for valid; does not accept.
    task automatic run_call(input int n, input bit m, input bit noise, output int lat);
        in_n  = n;
        mode  = m;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        lat = 0;
        while (valid_a !== 1'b1 && lat < 200) begin
            if (noise) begin
                ready = 1'($urandom_range(1));
                in_n  = $urandom_range(50);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        ready = 1'b0;
    endtask

    task automatic do_accept();
        accept = 1'b1;
        @(posedge clk);
        #1;
        accept = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({valid_a, out_a, ovf_a, busy_a} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_a: got v=%0b o=%0d f=%0b b=%0b want all 0",
                     valid_a, out_a, ovf_a, busy_a);
        end
        n_vec++;
        if ({valid_c, out_c, ovf_c, busy_c} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_c: got v=%0b o=%0d f=%0b b=%0b want all 0",
                     valid_c, out_c, ovf_c, busy_c);
        end
    endtask

    task automatic test_basic();
        int lat;
        run_call(10, 1'b0, 1'b0, lat);
        n_vec++;
        if (lat !== 10) begin n_err++; $display("FAIL basic_lat: got %0d want 10", lat); end
        n_vec++;
        if (out_a !== 32'd55 || ovf_a !== 1'b0) begin
            n_err++;
            $display("FAIL basic_out: got %0d ovf %0b want 55 ovf 0", out_a, ovf_a);
        end
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (valid_a !== 1'b1 || out_a !== 32'd55) begin
            n_err++;
            $display("FAIL basic_hold: got v=%0b o=%0d want v=1 o=55", valid_a, out_a);
        end
        do_accept();
        n_vec++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL basic_accept: got v=%0b b=%0b want 0 0", valid_a, busy_a);
        end
    endtask

    // Boundary arguments and Lucas values from fixed tables.
    task automatic test_fixed();
        int ns [5] = '{0, -7, 1, 5, 10};
        bit ms [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int ex [5] = '{0, 2, 1, 11, 123};
        int lat;
        for (int k = 0; k < 5; k++) begin
            run_call(ns[k], ms[k], 1'b0, lat);
            n_vec++;
            if (lat !== exp_lat(ns[k]) || out_a !== 32'(ex[k]) || ovf_a !== 1'b0) begin
                n_err++;
                $display("FAIL fixed n=%0d m=%0b: got lat %0d out %0d ovf %0b want %0d %0d 0",
                         ns[k], ms[k], lat, out_a, ovf_a, exp_lat(ns[k]), ex[k]);
            end
            do_accept();
        end
    endtask

    task automatic test_width();
        int ns [3] = '{13, 14, 20};
        logic [7:0] eb [3] = '{8'd233, 8'd121, 8'd109};
        logic [7:0] ec [3] = '{8'd233, 8'd255, 8'd255};
        bit ef [3] = '{1'b0, 1'b1, 1'b1};
        int lat;
        for (int k = 0; k < 3; k++) begin
            run_call(ns[k], 1'b0, 1'b0, lat);
            n_vec++;
            if (valid_b !== 1'b1 || out_b !== eb[k] || ovf_b !== ef[k]) begin
                n_err++;
                $display("FAIL width_wrap n=%0d: got %0d ovf %0b want %0d ovf %0b",
                         ns[k], out_b, ovf_b, eb[k], ef[k]);
            end
            n_vec++;
            if (valid_c !== 1'b1 || out_c !== ec[k] || ovf_c !== ef[k]) begin
                n_err++;
                $display("FAIL width_sat n=%0d: got %0d ovf %0b want %0d ovf %0b",
                         ns[k], out_c, ovf_c, ec[k], ef[k]);
            end
            do_accept();
        end
    endtask

    task automatic test_random();
        int lat, n;
        bit m;
        longint unsigned tv;
        bit f32, f8;
        logic [7:0] sat8;
        for (int k = 0; k < 25; k++) begin
            n  = int'($urandom_range(100)) - 20;
            m  = 1'($urandom_range(1));
            tv = true_val(n, m);
            f32 = (tv >= 64'h1_0000_0000);
            f8  = (tv >= 64'd256);
            sat8 = f8 ? 8'hff : tv[7:0];
            run_call(n, m, 1'b1, lat);
            n_vec++;
            if (lat !== exp_lat(n)) begin
                n_err++;
                $display("FAIL rand_lat n=%0d: got %0d want %0d", n, lat, exp_lat(n));
            end
            n_vec++;
            if (out_a !== tv[31:0] || ovf_a !== f32) begin
                n_err++;
                $display("FAIL rand_a n=%0d m=%0b: got %0d ovf %0b want %0d ovf %0b",
                         n, m, out_a, ovf_a, tv[31:0], f32);
            end
            n_vec++;
            if (out_b !== tv[7:0] || ovf_b !== f8 || out_c !== sat8 || ovf_c !== f8) begin
                n_err++;
                $display("FAIL rand_8 n=%0d m=%0b: got b=%0d/%0b c=%0d/%0b want %0d %0d ovf %0b",
                         n, m, out_b, ovf_b, out_c, ovf_c, tv[7:0], sat8, f8);
            end
            // Abort and ready are ignored while a result is held.
            abort = 1'b1;
            ready = 1'b1;
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
            abort = 1'b0;
            ready = 1'b0;
            n_vec++;
            if (valid_a !== 1'b1 || out_a !== tv[31:0]) begin
                n_err++;
                $display("FAIL rand_hold n=%0d: got v=%0b o=%0d want v=1 o=%0d",
                         n, valid_a, out_a, tv[31:0]);
            end
            do_accept();
        end
    endtask

    task automatic test_abort();
        int lat;
        in_n  = 30;
        mode  = 1'b0;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        n_vec++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || busy_c !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got busy=%0b valid=%0b want 0 0", busy_a, valid_a);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL abort_novalid: got %0b want 0", valid_a);
        end
        run_call(3, 1'b0, 1'b0, lat);
        n_vec++;
        if (lat !== 3 || out_a !== 32'd2) begin
            n_err++;
            $display("FAIL abort_next: got lat %0d out %0d want 3 2", lat, out_a);
        end
        do_accept();
    endtask

    task automatic test_mid_reset();
        int lat;
        in_n  = 30;
        mode  = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++;
        if ({valid_a, out_a, ovf_a, busy_a} !== 35'd0) begin
            n_err++;
            $display("FAIL rst_loop: got v=%0b o=%0d f=%0b b=%0b want all 0",
                     valid_a, out_a, ovf_a, busy_a);
        end
        run_call(14, 1'b0, 1'b0, lat);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++;
        if ({valid_a, out_a, ovf_a, busy_a} !== 35'd0 ||
            {valid_c, out_c, ovf_c, busy_c} !== 11'd0) begin
            n_err++;
            $display("FAIL rst_done: got v=%0b o=%0d c=%0d f=%0b b=%0b want all 0",
                     valid_a, out_a, out_c, ovf_c, busy_a);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL rst_quiet: got v=%0b b=%0b want 0 0", valid_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_call(4, 1'b0, 1'b0, lat);
        in_n   = 6;
        mode   = 1'b0;
        ready  = 1'b1;
        accept = 1'b1;
        @(posedge clk);
        #1;
        accept = 1'b0;
        n_vec++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_nocapture: got v=%0b b=%0b want 0 0", valid_a, busy_a);
        end
        @(posedge clk);
        #1;
        ready = 1'b0;
        n_vec++;
        if (busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_capture: got busy %0b want 1", busy_a);
        end
        lat = 0;
        while (valid_a !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_vec++;
        if (lat !== 6 || out_a !== 32'd8) begin
            n_err++;
            $display("FAIL b2b_result: got lat %0d out %0d want 6 8", lat, out_a);
        end
        do_accept();
    endtask

    initial begin
        fib_tab[0] = 0;
        fib_tab[1] = 1;
        for (int k = 2; k <= 82; k++) fib_tab[k] = fib_tab[k-1] + fib_tab[k-2];
        test_reset();
        test_basic();
        test_fixed();
        test_width();
        test_random();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
